// File: rtl/ped_request_pkg.sv
// Shared definitions for the pedestrian request path: clock rate and FSM state encodings
// that the traffic-light controller also relies on.
package ped_request_pkg;

    localparam int CLK_HZ = 50_000_000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

endpackage

// File: rtl/ped_request_edge_detect.sv
// Rising-edge detector on a clk-domain level. The previous-value register resets to RESET_VAL
// so that a level already high when reset releases is not taken as an edge.
module edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= d;
        end
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/ped_request.sv
// Turns the debounced button level into a held pedestrian request for the traffic-light
// controller, with a press pulse, a saturating press counter and a re-arm holdoff after service.
module ped_request
    import ped_request_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = CLK_HZ,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button_state,
    input  logic             ped_ack,
    output logic             ped_req,
    output logic             press_pulse,
    output logic [CNT_W-1:0] press_count,
    output logic             busy
);

    localparam int                 HOLD_W    = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    state_e            state_q, state_d;
    logic              ped_req_q, ped_req_d;
    logic              pulse_q, pulse_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              rise;

    edge_detect #(
        .RESET_VAL (1'b1)
    ) u_edge (
        .clk   (clk),
        .reset (reset),
        .d     (button_state),
        .rise  (rise)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ped_req_q <= 1'b0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            ped_req_q <= ped_req_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
            hold_q    <= hold_d;
        end
    end

    // The pulse follows every rise regardless of state; only IDLE turns a rise into a request.
    always_comb begin
        state_d   = state_q;
        ped_req_d = ped_req_q;
        pulse_d   = rise;
        busy_d    = busy_q;
        count_d   = count_q;
        hold_d    = hold_q;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d   = ST_REQ;
                    ped_req_d = 1'b1;
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            ST_REQ: begin
                if (ped_ack) begin
                    state_d   = ST_HOLDOFF;
                    ped_req_d = 1'b0;
                    busy_d    = 1'b1;
                    hold_d    = HOLD_LOAD;
                end
            end
            ST_HOLDOFF: begin
                if (hold_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                ped_req_d = 1'b0;
                busy_d    = 1'b0;
                hold_d    = '0;
            end
        endcase
    end

    assign ped_req     = ped_req_q;
    assign press_pulse = pulse_q;
    assign busy        = busy_q;
    assign press_count = count_q;

endmodule

// File: tb/tb_ped_request.sv
// Directed bench for ped_request: a behavioural model predicts outputs per cycle into a
// scoreboard queue, which is popped and checked just after each active clock edge.
module tb_ped_request;

    localparam int HOLD    = 8;
    localparam int CW      = 3;
    localparam int CNT_TOP = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          button_state;
    logic          ped_ack;
    logic          ped_req;
    logic          press_pulse;
    logic [CW-1:0] press_count;
    logic          busy;

    typedef struct {
        string tag;
        logic  req;
        logic  pulse;
        logic  busy;
        int    cnt;
    } exp_t;

    exp_t sb[$];

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state
    logic mPrev;
    int   mMode;
    logic mReq;
    logic mPulse;
    logic mBusy;
    int   mCnt;
    int   mLeft;

    ped_request #(
        .HOLDOFF_CYCLES (HOLD),
        .CNT_W          (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .button_state (button_state),
        .ped_ack      (ped_ack),
        .ped_req      (ped_req),
        .press_pulse  (press_pulse),
        .press_count  (press_count),
        .busy         (busy)
    );

    always #10 clk = ~clk;

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        assertCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mPrev  = 1'b1;
        mMode  = 0;
        mReq   = 1'b0;
        mPulse = 1'b0;
        mBusy  = 1'b0;
        mCnt   = 0;
        mLeft  = 0;
    endtask

    // Mode 0 waiting, 1 request pending, 2 holdoff with mLeft busy cycles still to run.
    task automatic modelStep(input logic btn, input logic ack);
        logic r;
        r      = btn & ~mPrev;
        mPrev  = btn;
        mPulse = r;
        case (mMode)
            0: if (r) begin
                mMode = 1;
                mReq  = 1'b1;
                if (mCnt < CNT_TOP) mCnt++;
            end
            1: if (ack) begin
                mMode = 2;
                mReq  = 1'b0;
                mBusy = 1'b1;
                mLeft = HOLD;
            end
            default: begin
                mLeft--;
                if (mLeft == 0) begin
                    mMode = 0;
                    mBusy = 1'b0;
                end
            end
        endcase
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            assertCount++;
            failCount++;
            $error("[TB] FAIL scoreboard: observed empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            checkVal({e.tag, "_req"},   8'(ped_req),     8'(e.req));
            checkVal({e.tag, "_pulse"}, 8'(press_pulse), 8'(e.pulse));
            checkVal({e.tag, "_busy"},  8'(busy),        8'(e.busy));
            checkVal({e.tag, "_count"}, 8'(press_count), 8'(e.cnt));
        end
    endtask

    task automatic applyStimulus(input logic btn, input logic ack, input string tag);
        exp_t e;
        button_state = btn;
        ped_ack      = ack;
        modelStep(btn, ack);
        e.tag   = tag;
        e.req   = mReq;
        e.pulse = mPulse;
        e.busy  = mBusy;
        e.cnt   = mCnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        reset        = 1'b0;
        button_state = 1'b1;
        ped_ack      = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_req",   8'(ped_req),     8'd0);
        checkVal("rst_pulse", 8'(press_pulse), 8'd0);
        checkVal("rst_busy",  8'(busy),        8'd0);
        checkVal("rst_count", 8'(press_count), 8'd0);
        reset = 1'b1;

        $display("[TB] held button through reset release");
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, "t1_held");

        $display("[TB] basic press, ack and holdoff");
        applyStimulus(1'b0, 1'b0, "t2_low");
        applyStimulus(1'b1, 1'b0, "t2_rise");
        checkVal("t2_req_now", 8'(ped_req), 8'd1);
        applyStimulus(1'b1, 1'b0, "t2_hold");
        applyStimulus(1'b1, 1'b0, "t2_hold");
        applyStimulus(1'b1, 1'b1, "t2_ack");
        for (int i = 0; i < HOLD + 2; i++) applyStimulus(1'b1, 1'b0, "t2_holdoff");
        applyStimulus(1'b0, 1'b0, "t2_release");

        $display("[TB] extra presses during REQ and HOLDOFF");
        applyStimulus(1'b1, 1'b0, "t3_rise");
        applyStimulus(1'b0, 1'b0, "t3_low");
        applyStimulus(1'b1, 1'b0, "t3_req_rise");
        applyStimulus(1'b0, 1'b1, "t3_ack");
        applyStimulus(1'b1, 1'b0, "t3_ho_rise");
        applyStimulus(1'b0, 1'b0, "t3_ho_low");
        for (int i = 0; i < HOLD - 3; i++) applyStimulus(1'b0, 1'b0, "t3_ho");
        applyStimulus(1'b1, 1'b0, "t3_exit_rise");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, "t3_after");
        checkVal("t3_no_req", 8'(ped_req), 8'd0);

        $display("[TB] ack and rise on the same edge");
        applyStimulus(1'b0, 1'b0, "t4_low");
        applyStimulus(1'b1, 1'b0, "t4_rise");
        applyStimulus(1'b0, 1'b0, "t4_low2");
        applyStimulus(1'b1, 1'b1, "t4_ack_rise");
        checkVal("t4_busy_now", 8'(busy), 8'd1);
        for (int i = 0; i < HOLD + 1; i++) applyStimulus(1'b0, 1'b0, "t4_holdoff");

        $display("[TB] asynchronous reset during holdoff");
        applyStimulus(1'b1, 1'b0, "t6_rise");
        applyStimulus(1'b1, 1'b1, "t6_ack");
        applyStimulus(1'b1, 1'b0, "t6_ho");
        applyStimulus(1'b1, 1'b0, "t6_ho");
        #5;
        reset = 1'b0;
        #1;
        checkVal("t6_busy",  8'(busy),        8'd0);
        checkVal("t6_req",   8'(ped_req),     8'd0);
        checkVal("t6_count", 8'(press_count), 8'd0);
        button_state = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        modelReset();

        $display("[TB] counter saturation over nine requests");
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1'b0, 1'b0, "t5_low");
            applyStimulus(1'b1, 1'b0, "t5_rise");
            checkVal("t5_count", 8'(press_count), 8'((i < CNT_TOP) ? i : CNT_TOP));
            applyStimulus(1'b1, 1'b1, "t5_ack");
            for (int j = 0; j < HOLD; j++) applyStimulus(1'b1, 1'b0, "t5_holdoff");
        end

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
